// File: rtl/sa_pkg.sv
// Shared types and arithmetic helpers for the systolic-array tiles.
// Build option: define SA_SATURATE_EN to clamp results instead of wrapping.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN
  } sa_state_e;

  // Working width for the round/saturate helper; must exceed any tile's ACC_WIDTH.
  localparam int SA_MAX_W = 128;

  function automatic int sa_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sa_acc_w(input int dw, input int k_depth);
    return 2 * dw + $clog2(k_depth) + 1;
  endfunction

  // acc must arrive already sign- or zero-extended to SA_MAX_W by the caller.
  function automatic logic [SA_MAX_W-1:0] sa_round_sat(input logic [SA_MAX_W-1:0] acc,
                                                       input int dw, input int frac,
                                                       input logic is_signed);
    logic [SA_MAX_W-1:0]        one;
    logic signed [SA_MAX_W-1:0] v;
`ifdef SA_SATURATE_EN
    logic signed [SA_MAX_W-1:0] lim_hi;
    logic signed [SA_MAX_W-1:0] lim_lo;
`endif
    one = {{(SA_MAX_W-1){1'b0}}, 1'b1};
    v   = $signed(acc);
    if (frac > 0) v = v + $signed(one << (frac - 1));
    if (is_signed) v = v >>> frac;
    else           v = $signed($unsigned(v) >> frac);
`ifdef SA_SATURATE_EN
    if (is_signed) begin
      lim_hi = $signed((one << (dw - 1)) - one);
      lim_lo = -$signed(one << (dw - 1));
    end else begin
      lim_hi = $signed((one << dw) - one);
      lim_lo = '0;
    end
    if (v > lim_hi)      v = lim_hi;
    else if (v < lim_lo) v = lim_lo;
    return v;
`else
    return v & ((one << dw) - one);
`endif
  endfunction

endpackage

// File: rtl/sa_pe_acc.sv
// Output-stationary processing element: registered operand pass-through
// (A to the right, B downward) and a full-width multiply-accumulate.
module sa_pe_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 37
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PW = 2 * DATA_WIDTH + 2;

  logic signed [DATA_WIDTH:0] a_ext;
  logic signed [DATA_WIDTH:0] b_ext;
  logic signed [PW-1:0]       prod;
  logic [ACC_WIDTH-1:0]       prod_acc;

  // One extra operand bit lets a single signed multiplier serve both modes.
  assign a_ext    = $signed({signed_mode & a_in[DATA_WIDTH-1], a_in});
  assign b_ext    = $signed({signed_mode & b_in[DATA_WIDTH-1], b_in});
  assign prod     = PW'(a_ext) * PW'(b_ext);
  assign prod_acc = ACC_WIDTH'(prod);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clear) acc <= '0;
      else       acc <= acc + prod_acc;
    end
  end

endmodule

// File: rtl/os_sa_tile.sv
// Output-stationary systolic matmul tile with operand skew, valid/ready
// streaming, round/saturate and row-serial drain. Option: SA_SATURATE_EN.
module os_sa_tile
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int K_DEPTH    = 16,
  parameter int FRAC_BITS  = DATA_WIDTH / 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    in_a,
  input  logic [COLS*DATA_WIDTH-1:0]    in_b,
  input  logic                          signed_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*DATA_WIDTH-1:0]    out_row,
  output logic [sa_idx_w(ROWS)-1:0]     out_row_idx,
  output logic                          busy
);

  localparam int ACC_WIDTH = sa_acc_w(DATA_WIDTH, K_DEPTH);
  localparam int IDX_W     = sa_idx_w(ROWS);
  localparam int BEAT_W    = $clog2(K_DEPTH + 1);
  localparam int FLUSH_W   = sa_idx_w(ROWS + COLS);

  sa_state_e            state_q, state_d;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic [IDX_W-1:0]     row_idx;
  logic                 mode_q;
  logic                 accept;
  logic                 flush_last;
  logic                 row_take;

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (K_DEPTH == 1) ? FLUSH : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && beat_cnt == BEAT_W'(K_DEPTH - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_W'(ROWS + COLS - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && row_idx == IDX_W'(ROWS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign flush_last = (state_q == FLUSH) && (flush_cnt == FLUSH_W'(ROWS + COLS - 1));
  assign row_take   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_idx   <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) beat_cnt <= (state_q == IDLE) ? BEAT_W'(1) : beat_cnt + 1'b1;
      // Mode is frozen for the whole tile once the first beat lands.
      if (accept && state_q == IDLE) mode_q <= signed_mode;
      flush_cnt <= (state_q == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (row_take) row_idx <= (row_idx == IDX_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    end
  end

  // Operand grid: a_h flows right along each row, b_v flows down each column.
  logic [DATA_WIDTH-1:0] a_h [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] b_v [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  acc [ROWS][COLS];

  // Skew chains run every cycle; an idle cycle injects zeros so bubbles
  // contribute nothing and never shift later beats out of alignment.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic [DATA_WIDTH-1:0] sk [r+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= r; i++) sk[i] <= '0;
      end else begin
        sk[0] <= accept ? in_a[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int i = 1; i <= r; i++) sk[i] <= sk[i-1];
      end
    end
    assign a_h[r][0] = sk[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic [DATA_WIDTH-1:0] sk [c+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= c; i++) sk[i] <= '0;
      end else begin
        sk[0] <= accept ? in_b[c*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int i = 1; i <= c; i++) sk[i] <= sk[i-1];
      end
    end
    assign b_v[0][c] = sk[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (state_q == IDLE),
        .signed_mode (mode_q),
        .a_in        (a_h[r][c]),
        .b_in        (b_v[r][c]),
        .a_out       (a_h[r][c+1]),
        .b_out       (b_v[r+1][c]),
        .acc         (acc[r][c])
      );
    end
  end

  logic [DATA_WIDTH-1:0] res_d [ROWS][COLS];
  logic [DATA_WIDTH-1:0] bank  [ROWS][COLS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        res_d[r][c] = DATA_WIDTH'(sa_round_sat(
                        mode_q ? SA_MAX_W'($signed(acc[r][c])) : SA_MAX_W'(acc[r][c]),
                        DATA_WIDTH, FRAC_BITS, mode_q));
      end
    end
  end

  // NOTE: the result bank is a small register array, not RAM, so it is
  // reset; that keeps out_row at zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) bank[r][c] <= '0;
    end else if (flush_last) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) bank[r][c] <= res_d[r][c];
    end
  end

  always_comb begin
    out_row = '0;
    for (int c = 0; c < COLS; c++) out_row[c*DATA_WIDTH +: DATA_WIDTH] = bank[row_idx][c];
  end

  assign out_row_idx = row_idx;

endmodule

// File: tb/tb_os_sa_tile.sv
// Self-checking bench for os_sa_tile (2x2 array, K=4, Q8 results) against a
// plain-arithmetic matrix-product model; honours SA_SATURATE_EN.
`timescale 1ns/1ps
module tb_os_sa_tile;

  localparam int DW = 16;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int K  = 4;
  localparam int FB = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [R*DW-1:0] in_a = '0;
  logic [C*DW-1:0] in_b = '0;
  logic            signed_mode = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [C*DW-1:0] out_row;
  logic [0:0]      out_row_idx;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_edge = 0;

  logic [DW-1:0] a_m [R][K];
  logic [DW-1:0] b_m [K][C];

  os_sa_tile #(
    .DATA_WIDTH (DW),
    .ROWS       (R),
    .COLS       (C),
    .K_DEPTH    (K),
    .FRAC_BITS  (FB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // C[r][c] = sum_k A[r][k]*B[k][c], round half up at FB, then clamp or wrap.
  function automatic logic [DW-1:0] ref_c(input int r, input int c, input bit sm);
    longint s = 0;
    longint v;
    logic [63:0] bits;
    for (int k = 0; k < K; k++) begin
      if (sm) s += longint'($signed(a_m[r][k])) * longint'($signed(b_m[k][c]));
      else    s += longint'(a_m[r][k]) * longint'(b_m[k][c]);
    end
    v = (s + (longint'(1) << (FB - 1))) >>> FB;
`ifdef SA_SATURATE_EN
    if (sm) begin
      if (v > 32767)       v = 32767;
      else if (v < -32768) v = -32768;
    end else if (v > 65535) begin
      v = 65535;
    end
`endif
    bits = v;
    return bits[DW-1:0];
  endfunction

  task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int r = 0; r < R; r++) for (int k = 0; k < K; k++) a_m[r][k] = a;
    for (int k = 0; k < K; k++) for (int c = 0; c < C; c++) b_m[k][c] = b;
  endtask

  task automatic fill_random();
    for (int r = 0; r < R; r++) for (int k = 0; k < K; k++) a_m[r][k] = DW'($urandom());
    for (int k = 0; k < K; k++) for (int c = 0; c < C; c++) b_m[k][c] = DW'($urandom());
  endtask

  // Streams K beats; signed_mode is flipped after the first beat to show it is ignored.
  task automatic send_tile(input bit sm, input int gap_at, input int gap_len, input bit rand_gaps);
    int k = 0;
    int gap = gap_len;
    int guard = 0;
    bit hold;
    while (k < K && guard < 200) begin
      @(negedge clk);
      guard++;
      signed_mode = (k == 0) ? sm : ~sm;
      hold = 1'b0;
      if (k == gap_at && gap > 0) begin
        hold = 1'b1;
        gap--;
      end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
        hold = 1'b1;
      end
      if (hold) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int r = 0; r < R; r++) in_a[r*DW +: DW] = a_m[r][k];
        for (int c = 0; c < C; c++) in_b[c*DW +: DW] = b_m[k][c];
      end
      if (in_valid && in_ready) begin
        k++;
        last_edge = cyc + 1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    check("beats_sent", k, K);
  endtask

  task automatic recv_tile(input bit sm, input int stall0, input bit rand_stall);
    int guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("out_valid_seen", out_valid, 1);
    check("latency", cyc - last_edge, R + C);
    check("busy_drain", busy, 1);
    for (int i = 0; i < R; i++) begin
      int st = (i == 0) ? stall0 : (rand_stall ? $urandom_range(0, 2) : 0);
      logic [C*DW-1:0] held = out_row;
      for (int s = 0; s < st; s++) begin
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_row", out_row, held);
        check("stall_idx", out_row_idx, i);
        check("stall_in_ready", in_ready, 0);
        check("stall_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      check($sformatf("row%0d_valid", i), out_valid, 1);
      check($sformatf("row%0d_idx", i), out_row_idx, i);
      for (int c = 0; c < C; c++)
        check($sformatf("row%0d_c%0d", i, c), out_row[c*DW +: DW], ref_c(i, c, sm));
      @(negedge clk);
      out_ready = 1'b0;
    end
    check("drain_valid_low", out_valid, 0);
    check("drain_idle", busy, 0);
    check("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_idx", out_row_idx, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: 0x0100 * 0x0200 * 4 beats -> 0x0800
    fill(16'h0100, 16'h0200);
    send_tile(1'b1, -1, 0, 1'b0);
    recv_tile(1'b1, 0, 1'b0);

    // Saturation / wrap
    fill(16'h7FFF, 16'h7FFF);
    send_tile(1'b1, -1, 0, 1'b0);
    recv_tile(1'b1, 0, 1'b0);

    // Signed then unsigned with a negative-looking operand
    fill(16'hFF00, 16'h0100);
    send_tile(1'b1, -1, 0, 1'b0);
    recv_tile(1'b1, 0, 1'b0);
    send_tile(1'b0, -1, 0, 1'b0);
    recv_tile(1'b0, 0, 1'b0);

    // Rounding edge: 128/256 rounds up, 127/256 rounds down
    fill(16'h0000, 16'h0000);
    for (int r = 0; r < R; r++) a_m[r][0] = 16'h0001;
    for (int c = 0; c < C; c++) b_m[0][c] = 16'd128;
    send_tile(1'b1, -1, 0, 1'b0);
    recv_tile(1'b1, 0, 1'b0);
    for (int c = 0; c < C; c++) b_m[0][c] = 16'd127;
    send_tile(1'b1, -1, 0, 1'b0);
    recv_tile(1'b1, 0, 1'b0);

    // Input bubbles before beat 3, then output backpressure on row 0
    fill(16'h0100, 16'h0200);
    send_tile(1'b1, 3, 3, 1'b0);
    recv_tile(1'b1, 0, 1'b0);
    send_tile(1'b1, -1, 0, 1'b0);
    recv_tile(1'b1, 5, 1'b0);

    // Reset during FLUSH aborts silently; next tile carries no residue
    fill_random();
    send_tile(1'b1, -1, 0, 1'b0);
    @(negedge clk);
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_row", out_row, 0);
    for (int i = 0; i < R + C + 3; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    fill(16'h0100, 16'h0200);
    send_tile(1'b1, -1, 0, 1'b0);
    recv_tile(1'b1, 0, 1'b0);

    // Randomised tiles with random bubbles and stalls
    for (int t = 0; t < 8; t++) begin
      bit sm;
      sm = 1'($urandom_range(0, 1));
      fill_random();
      send_tile(sm, -1, 0, 1'b1);
      recv_tile(sm, $urandom_range(0, 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
